// File: rtl/gnrl_rr_arb.sv
// gnrl_rr_arb: round-robin N:1 valid/ready arbiter that locks a stalled grant until it completes.
// Define GNRL_RR_ARB_OUT_REG_EN to insert a registered output slice (1-cycle latency).
module gnrl_rr_arb #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_vld,
    input  logic [N*DW-1:0] req_dat,
    output logic [N-1:0]  req_rdy,
    output logic          o_vld,
    output logic [DW-1:0] o_dat,
    output logic [IW-1:0] o_id,
    input  logic          o_rdy
);
    logic [IW-1:0] ptr, ptr_nxt, lock_idx, rr_sel, sel;
    logic          lock, any, a_vld, a_rdy, xfer;
    logic [DW-1:0] a_dat;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        rr_sel = ptr;
        for (int k = N - 1; k >= 0; k--)
            if (req_vld[(int'(ptr) + k) % N]) rr_sel = IW'((int'(ptr) + k) % N);
    end

    // Outputs are forced idle while reset is asserted so a stalled request is never transferred.
    always_comb begin
        any     = |req_vld;
        sel     = lock ? lock_idx : rr_sel;
        a_vld   = rst_n & (lock ? req_vld[lock_idx] : any);
        a_dat   = req_dat[int'(sel)*DW +: DW];
        xfer    = a_vld & a_rdy;
        ptr_nxt = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
        for (int i = 0; i < N; i++) req_rdy[i] = xfer && (int'(sel) == i);
    end

    // A dropped locked request leaves a_vld low, which clears the lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (xfer) ptr <= ptr_nxt;
            lock <= a_vld & ~a_rdy;
            if (a_vld & ~a_rdy) lock_idx <= sel;
        end
    end

`ifdef GNRL_RR_ARB_OUT_REG_EN
    assign a_rdy = ~o_vld | o_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            o_id  <= '0;
        end else if (xfer) begin
            o_vld <= 1'b1;
            o_dat <= a_dat;
            o_id  <= sel;
        end else if (o_rdy) begin
            o_vld <= 1'b0;
        end
    end
`else
    assign a_rdy = o_rdy;
    assign o_vld = a_vld;
    assign o_dat = a_dat;
    assign o_id  = sel;
`endif
endmodule

// File: tb/tb_gnrl_rr_arb.sv
// tb_gnrl_rr_arb: directed vector-table bench for gnrl_rr_arb (N=4) plus a N=3 instance.
module tb_gnrl_rr_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [127:0] req_dat;
    logic [3:0]  req_rdy;
    logic        o_vld, o_rdy;
    logic [31:0] o_dat;
    logic [1:0]  o_id;
    logic [2:0]  req_vld3;
    logic [95:0] req_dat3;
    logic [2:0]  req_rdy3;
    logic        o_vld3, o_rdy3;
    logic [31:0] o_dat3;
    logic [1:0]  o_id3;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gnrl_rr_arb #(.N(4), .DW(32), .IW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_dat(req_dat), .req_rdy(req_rdy),
        .o_vld(o_vld), .o_dat(o_dat), .o_id(o_id), .o_rdy(o_rdy)
    );

    gnrl_rr_arb #(.N(3), .DW(32), .IW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld3), .req_dat(req_dat3), .req_rdy(req_rdy3),
        .o_vld(o_vld3), .o_dat(o_dat3), .o_id(o_id3), .o_rdy(o_rdy3)
    );

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic       e_vld;
        logic [1:0] e_id;
        logic [3:0] e_rrdy;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ptr walks 0->1->2->3->0; stall on 2 with req0 arriving; drop of locked req1; lock holds vs higher priority req0
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[6]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[7]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[8]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[9]  = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[10] = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[11] = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[12] = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[13] = '{4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[14] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[15] = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[16] = '{4'b1011, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[17] = '{4'b1011, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[18] = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001};

        for (int i = 0; i < 4; i++) req_dat[i*32 +: 32] = 32'h100 + i;
        for (int i = 0; i < 3; i++) req_dat3[i*32 +: 32] = 32'h200 + i;
        rst_n = 1'b0; req_vld = '0; o_rdy = 1'b1; req_vld3 = '0; o_rdy3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ptr", 32'(dut.ptr), 32'd0);
        chk("reset_lock", 32'(dut.lock), 32'd0);

        for (int i = 0; i < 19; i++) begin
            next_cycle();
            req_vld = tbl[i].vld;
            o_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_vld", i), 32'(o_vld), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_rrdy", i), 32'(req_rdy), 32'(tbl[i].e_rrdy));
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d_id", i), 32'(o_id), 32'(tbl[i].e_id));
                chk($sformatf("v%0d_dat", i), o_dat, 32'h100 + 32'(tbl[i].e_id));
            end
        end

        next_cycle();
        req_vld = '0;
        req_vld3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("n3_%0d_id", i), 32'(o_id3), (i % 2 == 0) ? 32'd0 : 32'd2);
            chk($sformatf("n3_%0d_dat", i), o_dat3, (i % 2 == 0) ? 32'h200 : 32'h202);
            chk($sformatf("n3_%0d_rrdy", i), 32'(req_rdy3), (i % 2 == 0) ? 32'd1 : 32'd4);
            chk($sformatf("n3_%0d_ptr", i), 32'(dut3.ptr < 2'd3), 32'd1);
            next_cycle();
        end
        req_vld3 = '0;

        req_vld = 4'b0010; o_rdy = 1'b1;
        @(negedge clk);
        chk("rs_pre_id", 32'(o_id), 32'd1);
        next_cycle();
        req_vld = 4'b1000; o_rdy = 1'b0;
        @(negedge clk);
        chk("rs_stall_id", 32'(o_id), 32'd3);
        chk("rs_stall_rrdy", 32'(req_rdy), 32'd0);
        next_cycle();
        chk("rs_lock_set", 32'(dut.lock), 32'd1);
        chk("rs_ptr2", 32'(dut.ptr), 32'd2);
        #2 o_rdy = 1'b1; rst_n = 1'b0;
        #1;
        chk("rs_vld", 32'(o_vld), 32'd0);
        chk("rs_rrdy", 32'(req_rdy), 32'd0);
        chk("rs_lock", 32'(dut.lock), 32'd0);
        chk("rs_ptr", 32'(dut.ptr), 32'd0);
        @(posedge clk);
        #1;
        chk("rs_hold_rrdy", 32'(req_rdy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rs_post_id", 32'(o_id), 32'd3);
        chk("rs_post_dat", o_dat, 32'h103);
        chk("rs_post_rrdy", 32'(req_rdy), 32'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gnrl_rr_arb.md
Name: gnrl_rr_arb

Overview:
- Round-robin arbiter that shares one downstream consumer among N requesters. Typical consumer: the register-file write-back port built from the general DFF library.
- Each requester uses a valid/ready handshake. The winning requester's payload and index go to a single output channel.
- A granted-but-stalled request stays locked to the output until it completes.
- Optional registered output slice for timing.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 32, payload width per requester
- IW, 2, index width; must satisfy 2^IW >= N

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_vld  input  N  request valid, bit i = requester i
- req_dat  input  N*DW  payloads; requester i occupies bits [i*DW +: DW]
- req_rdy  output  N  request accepted; one-hot or zero
- o_vld  output  1  output valid
- o_dat  output  DW  payload of the granted requester
- o_id  output  IW  index of the granted requester
- o_rdy  input  1  consumer ready

Behaviour:
- State registers:
  - ptr [IW]: highest-priority index, reset 0.
  - lock [1]: reset 0.
  - lock_idx [IW]: reset 0.
  - Build these from the general DFFs with reset value 0.
- Selection, combinational, internal sel/any:
  - If lock=1, sel=lock_idx.
  - Otherwise sel = first i with req_vld[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - any = |req_vld.
  - If no request is valid, sel=ptr.
- Internal channel: a_vld = lock ? req_vld[lock_idx] : any; a_dat = req_dat[sel]; a_id = sel.
- Handshake:
  - req_rdy[i] = a_vld & a_rdy & (sel==i). All other req_rdy bits are 0.
  - Exactly one transfer per cycle at most.
- Pointer update: on a transfer (a_vld & a_rdy), ptr <= (sel==N-1) ? 0 : sel+1. Otherwise ptr holds.
- Lock rules:
  - Set when a_vld & ~a_rdy: lock<=1, lock_idx<=sel.
  - Cleared on a transfer.
  - Also cleared if req_vld[lock_idx] drops while locked (protocol violation tolerated). Arbitration then reopens the next cycle.
  - While lock=1, newly arriving higher-priority requests must not change sel or a_dat.
- Stability guarantee: once a_vld=1 with a_rdy=0, a_id and a_dat (given a stable requester) hold until transfer.
- Without the output slice, latency is 0 cycles: o_vld=a_vld, o_dat=a_dat, o_id=a_id, a_rdy=o_rdy. All outputs are combinational; with req_vld=0 after reset, o_vld=0.
- Single requester continuously valid: granted every cycle o_rdy=1; ptr cycles past it.
- N not a power of two: indices >= N are never produced; the pointer wraps at N-1 -> 0.
- Reset asserted mid-stall: lock, ptr and any slice contents are cleared immediately and asynchronously. The in-flight request is not transferred.

Optional Feature:
- GNRL_RR_ARB_OUT_REG_EN defined: a registered output slice is inserted.
  - Slice registers: o_vld reset 0; o_dat and o_id reset 0.
  - a_rdy = ~o_vld | o_rdy.
  - On a_vld & a_rdy, the slice loads a_dat/a_id and o_vld<=1.
  - On o_vld & o_rdy with no new load, o_vld<=0.
  - Latency 1 cycle; full throughput of 1 transfer/cycle while o_rdy=1.
  - Lock and ptr rules apply to the internal a_* handshake.
- Macro undefined: zero-latency combinational path as above. No slice registers exist.

Test Plan:
- Reset, then req_vld=4'b0000, o_rdy=1 -> o_vld=0, req_rdy=0, ptr=0. With the macro: o_vld=0, o_dat=0, o_id=0.
- req_vld=4'b1111 held, o_rdy=1, dat_i=32'h100+i -> o_id sequence 0,1,2,3,0. o_dat is 32'h100,101,102,103,100, one per cycle (with macro: same sequence, delayed 1 cycle).
- req_vld=4'b0100, o_rdy=0 for 3 cycles, then req0 also asserted, then o_rdy=1 -> o_id=2 held through the stall, req_rdy=4'b0100 on the release cycle. The next grant is 0 (ptr=3 wraps to 0).
- Locked on idx 1, requester 1 drops req_vld with req3 valid -> lock cleared. The next cycle grants idx 3, no transfer for idx 1.
- N=3, req_vld=3'b101, o_rdy=1 -> grants alternate 0,2,0,2. o_id never equals 3.
- Stall with lock=1 and ptr=2, assert rst_n=0 for 1 cycle -> lock=0, ptr=0, o_vld=0 immediately, no req_rdy pulse.
